mc_hs_controller: RTL
=====================

// Module: mc_hs_controller
// PURPOSE
//  Multi-cycle MIPS-subset control FSM with a variable-latency memory handshake. It replaces the
//  fixed-latency controller in the multi-cycle CPU. It drives every datapath select/enable.
//  Stalls in any memory state until mem_ready; a memory wait longer than MEM_TIMEOUT cycles, or an
//  illegal opcode, traps the core. Sits between the instruction register and the datapath muxes.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles a memory state may wait for mem_ready before trapping (>=1)
//  WAIT_W       5   width of wait counter; must hold MEM_TIMEOUT
//  CNT_W        32  width of performance counters
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-low reset
//  opcode       in   6      IR[31:26]
//  funct        in   6      IR[5:0]
//  zero         in   1      ALU zero flag (combinational, current cycle)
//  mem_ready    in   1      memory completes the current access this cycle
//  pc_write     out  1      load PC
//  iord         out  1      0: mem addr=PC, 1: mem addr=ALUOut
//  mem_read     out  1      read request, held until mem_ready
//  mem_write    out  1      write request, held until mem_ready
//  ir_write     out  1      load IR
//  mem_to_reg   out  2      00 ALUOut, 01 MDR, 10 PC (link)
//  reg_dst      out  2      00 rt, 01 rd, 10 $31
//  reg_write    out  1      RF write enable
//  ext_op       out  1      1 sign-extend imm, 0 zero-extend
//  lui_op       out  1      imm<<16
//  alu_src_a    out  2      00 A, 01 PC, 10 shamt
//  alu_src_b    out  2      00 B, 01 const 4, 10 imm, 11 imm<<2
//  alu_op       out  4      0 add,1 sub,2 funct,3 and,4 or,5 slt,6 sltu,7 pass-B
//  pc_source    out  2      00 ALU result, 01 ALUOut, 10 jump target
//  trap         out  1      sticky; 1 = core halted
//  trap_cause   out  2      01 illegal opcode/funct, 10 memory timeout
//  cycle_cnt    out  CNT_W  cycles since reset (see CONFIGURATION)
//  retire_cnt   out  CNT_W  instructions retired (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): state=FETCH, wait_cnt=0, trap=0, trap_cause=0, counters=0.
//    Overrides any state, including mid-access and TRAP. All control outputs decode to 0 from state.
//  - Outputs are Moore (from state) except pc_write, ir_write and the FETCH->DECODE move.
//    These also depend on mem_ready (and on zero in BRANCH).
//  - States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, WB_R, WB_I, BRANCH, JUMP, TRAP.
//  - FETCH: mem_read=1, iord=0, alu_src_a=01, alu_src_b=01, alu_op=0, pc_source=00.
//    On mem_ready: ir_write=1, pc_write=1 (PC+4), go to DECODE. Otherwise hold all outputs.
//  - DECODE: alu_src_a=01, alu_src_b=11, alu_op=0 (branch target into ALUOut). Dispatch on opcode:
//    0x00 -> EXEC_R; 0x23/0x2b -> MEM_ADDR; 0x04/0x05 -> BRANCH; 0x02/0x03 -> JUMP;
//    0x08,0x09,0x0a,0x0b,0x0c,0x0d,0x0f -> EXEC_I; else TRAP (cause 01).
//  - EXEC_R: alu_op=2. sll/srl/sra (funct 0x00/0x02/0x03) use alu_src_a=10.
//    jr (0x08): pc_source=00 with ALU passing A, pc_write=1, -> FETCH.
//    jalr (0x09): same, plus reg_dst=01, mem_to_reg=10, reg_write=1.
//    Other funct -> WB_R.
//  - WB_R: reg_dst=01, mem_to_reg=00, reg_write=1 -> FETCH.
//  - EXEC_I: alu_src_b=10. ext_op=1 except andi/ori (0). lui_op=1 for 0x0f. alu_op per opcode -> WB_I.
//  - WB_I: reg_dst=00, mem_to_reg=00, reg_write=1 -> FETCH.
//  - MEM_ADDR: alu_src_b=10, ext_op=1, alu_op=0. Go to MEM_RD (lw) or MEM_WR (sw).
//  - MEM_RD/MEM_WR: iord=1, request held. On mem_ready go to MEM_WB (lw) or FETCH (sw).
//  - MEM_WB: mem_to_reg=01, reg_dst=00, reg_write=1 -> FETCH.
//  - BRANCH: alu_op=1, pc_source=01. pc_write = zero (beq) or !zero (bne). -> FETCH.
//  - JUMP: pc_source=10, pc_write=1. jal also sets reg_dst=10, mem_to_reg=10, reg_write=1. -> FETCH.
//  - Timeout: wait_cnt clears on entry to FETCH/MEM_RD/MEM_WR and increments each stalled cycle.
//    If mem_ready is still 0 when wait_cnt==MEM_TIMEOUT-1: go to TRAP, cause 10.
//    mem_ready high in that same cycle wins (no trap).
//  - TRAP: all controls 0, trap=1, stays until reset. Illegal funct in EXEC_R also traps (cause 01).
//  - Retire event: the final cycle of each instruction, i.e. the transition into FETCH from any
//    state other than reset.
// CONFIGURATION
//  MC_PERF_CNT_EN defined: cycle_cnt increments every cycle while trap==0.
//    retire_cnt increments on each retire event. Both wrap at 2^CNT_W.
//  Not defined: cycle_cnt and retire_cnt are tied to 0 and no counter flops are built.
// TESTING
//  - add $3,$1,$2 with mem_ready=1 always: FETCH,DECODE,EXEC_R,WB_R = 4 cycles.
//    reg_write=1 only in WB_R, reg_dst=01.
//  - lw with fetch mem_ready delayed 3 cycles: mem_read held 4 cycles, ir_write pulses exactly once.
//    Data phase ready after 2 cycles: total 4+1+1+3+1 = 10 cycles.
//  - beq with zero=1 -> pc_write=1, pc_source=01. bne with zero=1 -> pc_write=0. Both return to FETCH.
//  - MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH: TRAP entered after 4 stall cycles, trap_cause=10.
//    Outputs stay 0 until reset=0.
//  - opcode 0x3f: DECODE -> TRAP, trap_cause=01. Then reset=0 for one edge -> FETCH, trap=0.
//  - With MC_PERF_CNT_EN: 3 back-to-back add instructions give retire_cnt=3, cycle_cnt=12.
//    Without the macro both read 0.

Source files
------------

// File: rtl/mc_hs_controller.sv
// rtl/mc_hs_controller.sv - multi-cycle MIPS-subset control FSM with variable-latency memory handshake
// Optional performance counters are built only when MC_PERF_CNT_EN is defined.
module mc_hs_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int WAIT_W      = 5,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       reg_dst,
    output logic             reg_write,
    output logic             ext_op,
    output logic             lui_op,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WB,
        S_MEM_WR, S_WB_R, S_WB_I, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        cause_q, cause_d;
    logic              wait_expired;

    function automatic logic legal_funct(input logic [5:0] f);
        case (f)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2a, 6'h2b: legal_funct = 1'b1;
            default:      legal_funct = 1'b0;
        endcase
    endfunction

    assign wait_expired = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        wait_d     = '0;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 2'b00;
        reg_dst    = 2'b00;
        reg_write  = 1'b0;
        ext_op     = 1'b0;
        lui_op     = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 4'd0;
        pc_source  = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b11;
                case (opcode)
                    6'h00:        state_d = S_EXEC_R;
                    6'h23, 6'h2b: state_d = S_MEM_ADDR;
                    6'h04, 6'h05: state_d = S_BRANCH;
                    6'h02, 6'h03: state_d = S_JUMP;
                    6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f: state_d = S_EXEC_I;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_op = 4'd2;
                if (funct == 6'h00 || funct == 6'h02 || funct == 6'h03)
                    alu_src_a = 2'b10;
                if (!legal_funct(funct)) begin
                    state_d = S_TRAP;
                    cause_d = 2'b01;
                end else if (funct == 6'h08 || funct == 6'h09) begin
                    // ALU control passes A for jr/jalr, so the jump target is the ALU result.
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
                    if (funct == 6'h09) begin
                        reg_dst    = 2'b01;
                        mem_to_reg = 2'b10;
                        reg_write  = 1'b1;
                    end
                end else begin
                    state_d = S_WB_R;
                end
            end
            S_WB_R: begin
                reg_dst   = 2'b01;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_b = 2'b10;
                ext_op    = !(opcode == 6'h0c || opcode == 6'h0d);
                lui_op    = (opcode == 6'h0f);
                case (opcode)
                    6'h0a:   alu_op = 4'd5;
                    6'h0b:   alu_op = 4'd6;
                    6'h0c:   alu_op = 4'd3;
                    6'h0d:   alu_op = 4'd4;
                    6'h0f:   alu_op = 4'd7;
                    default: alu_op = 4'd0;
                endcase
                state_d = S_WB_I;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
                state_d   = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD, S_MEM_WR: begin
                iord      = 1'b1;
                mem_read  = (state_q == S_MEM_RD);
                mem_write = (state_q == S_MEM_WR);
                if (mem_ready) begin
                    state_d = (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_MEM_WB: begin
                mem_to_reg = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_op    = 4'd1;
                pc_source = 2'b01;
                pc_write  = (opcode == 6'h04) ? zero : !zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
                if (opcode == 6'h03) begin
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                    reg_write  = 1'b1;
                end
                state_d = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, ret_q;
    logic             retire;

    // An instruction retires on its last cycle: any move into FETCH (holding FETCH is a stall).
    assign retire = (state_d == S_FETCH) && (state_q != S_FETCH);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (!trap)
                cyc_q <= cyc_q + 1'b1;
            if (retire)
                ret_q <= ret_q + 1'b1;
        end
    end

    assign cycle_cnt  = cyc_q;
    assign retire_cnt = ret_q;
`else
    assign cycle_cnt  = '0;
    assign retire_cnt = '0;
`endif

endmodule
